// File: rtl/cell4_tt_sequencer_pkg.sv
// Shared definitions for the cell truth-table sequencers (NOR4 first,
// NAND4/AOI variants later): FSM state encodings and table-width helper.
package cell4_tt_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  // Number of truth-table entries for a cell with n inputs.
  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/cell4_tt_sequencer_settle_timer.sv
// Settle-window down-counter: load reloads LOAD_VAL, count_en decrements,
// expire flags the last held cycle so the FSM moves to SAMPLE on that edge.
module cell4_tt_sequencer_settle_timer #(
  parameter int unsigned LOAD_VAL = 2
) (
  input  logic CK,
  input  logic RN,
  input  logic load,
  input  logic count_en,
  output logic expire
);

  localparam int unsigned CW = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);
  localparam logic [CW-1:0] LOAD_W = CW'(LOAD_VAL);

  logic [CW-1:0] cnt;

  // Reload on each stim change, count down while holding.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_W;
    end else if (count_en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = count_en && (cnt == CW'(1));

endmodule

// File: rtl/cell4_tt_sequencer.sv
// Truth-table sweep/capture for 4-input library cells. Drives every input
// pattern onto stim, samples ZN after SETTLE_CYC hold cycles, builds tt and
// counts mismatches against EXP_TT.
// Optional: define CELL_TT_FIRST_FAIL_EN to add first_fail / fail_idx capture.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for start; results of last sweep held
// ST_SETTLE | stim held, settle timer running
// ST_SAMPLE | this edge captures ZN for idx and advances the pattern
// ST_DONE   | one cycle, done high, then back to idle
module cell4_tt_sequencer
  import cell4_tt_sequencer_pkg::*;
#(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [(2**N_IN)-1:0] EXP_TT = 16'h0001
) (
  input  logic                   CK,
  input  logic                   RN,
  input  logic                   start,
  output logic [N_IN-1:0]        stim,
  input  logic                   ZN,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   tt,
  output logic [N_IN:0]          err_cnt,
  output logic                   pass
`ifdef CELL_TT_FIRST_FAIL_EN
  ,
  output logic                   first_fail,
  output logic [N_IN-1:0]        fail_idx
`endif
);

  localparam int unsigned TT_W = tt_width(N_IN);
  // With no settle window the pattern is sampled on the very next edge.
  localparam tt_state_e ST_HOLD = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;

  tt_state_e       state;
  logic [N_IN-1:0] idx;
  logic            mismatch;
  logic            last;
  logic [N_IN:0]   err_nxt;
  logic            tmr_load;
  logic            tmr_expire;

  assign mismatch = (ZN != EXP_TT[idx]);
  assign last     = (idx == {N_IN{1'b1}});
  assign err_nxt  = err_cnt + (N_IN+1)'(mismatch);
  assign tmr_load = ((state == ST_IDLE) && start) || ((state == ST_SAMPLE) && !last);

  cell4_tt_sequencer_settle_timer #(
    .LOAD_VAL (SETTLE_CYC)
  ) u_settle_timer (
    .CK       (CK),
    .RN       (RN),
    .load     (tmr_load),
    .count_en (state == ST_SETTLE),
    .expire   (tmr_expire)
  );

  // Sweep FSM with all outputs registered.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state   <= ST_IDLE;
      idx     <= '0;
      stim    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tt      <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx     <= '0;
            stim    <= '0;
            tt      <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_HOLD;
          end
        end
        ST_SETTLE: begin
          if (tmr_expire) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          tt[idx] <= ZN;
          err_cnt <= err_nxt;
          if (last) begin
            stim  <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
            state <= ST_DONE;
          end else begin
            idx   <= idx + N_IN'(1);
            stim  <= idx + N_IN'(1);
            state <= ST_HOLD;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CELL_TT_FIRST_FAIL_EN
  // Remember the pattern index of the first mismatch in a sweep.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      first_fail <= 1'b0;
      fail_idx   <= '0;
    end else if ((state == ST_IDLE) && start) begin
      first_fail <= 1'b0;
      fail_idx   <= '0;
    end else if ((state == ST_SAMPLE) && mismatch && !first_fail) begin
      first_fail <= 1'b1;
      fail_idx   <= idx;
    end
  end
`endif

  initial assert (TT_W == (2**N_IN)) else $error("table width");

endmodule

// File: tb/tb_cell4_tt_sequencer.sv
// Directed bench: NOR4_X2 model on stim/ZN, one DUT with default settle and
// one with SETTLE_CYC=0.
`timescale 1ns/1ps
module tb_cell4_tt_sequencer;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic [1:0]  zn_mode = 2'd0;
  logic [3:0]  stim, stim0;
  logic        ZN, ZN0;
  logic        busy, busy0, done, done0, pass, pass0;
  logic [15:0] tt, tt0;
  logic [4:0]  err_cnt, err_cnt0;
`ifdef CELL_TT_FIRST_FAIL_EN
  logic        first_fail, first_fail0;
  logic [3:0]  fail_idx, fail_idx0;
`endif

  int total = 0;
  int bad   = 0;
  int done_cyc, n_done;
  logic [3:0] stim_k;
  logic       busy_k;

  always #5 CK = ~CK;

  // NOR4 cell model, with forced-low/forced-high fault modes.
  assign ZN  = (zn_mode == 2'd1) ? 1'b0 : (zn_mode == 2'd2) ? 1'b1 : ~|stim;
  assign ZN0 = ~|stim0;

  cell4_tt_sequencer #(.N_IN(4), .SETTLE_CYC(2), .EXP_TT(16'h0001)) u_dut (
    .CK(CK), .RN(RN), .start(start), .stim(stim), .ZN(ZN), .busy(busy),
    .done(done), .tt(tt), .err_cnt(err_cnt), .pass(pass)
`ifdef CELL_TT_FIRST_FAIL_EN
    , .first_fail(first_fail), .fail_idx(fail_idx)
`endif
  );

  cell4_tt_sequencer #(.N_IN(4), .SETTLE_CYC(0), .EXP_TT(16'h0001)) u_dut0 (
    .CK(CK), .RN(RN), .start(start0), .stim(stim0), .ZN(ZN0), .busy(busy0),
    .done(done0), .tt(tt0), .err_cnt(err_cnt0), .pass(pass0)
`ifdef CELL_TT_FIRST_FAIL_EN
    , .first_fail(first_fail0), .fail_idx(fail_idx0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One sweep: start before edge e0, optional extra start pulses and reset
  // at given cycle numbers, capture stim/busy at cycle sk, log done cycles.
  task automatic run_sweep(input bit sel0, input int p1, input int p2,
                           input int rst_at, input int sk);
    done_cyc = -1;
    n_done   = 0;
    @(negedge CK);
    if (sel0) start0 = 1'b1; else start = 1'b1;
    @(posedge CK);
    for (int k = 1; k <= 60; k++) begin
      @(negedge CK);
      start  = !sel0 && (k == p1 || k == p2);
      start0 = 1'b0;
      if (k == rst_at) RN = 1'b0;
      @(posedge CK);
      #1;
      if (sel0 ? done0 : done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k + 1;
      end
      if (k == sk) begin
        stim_k = sel0 ? stim0 : stim;
        busy_k = sel0 ? busy0 : busy;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    stim_k = '0;
    busy_k = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_stim",  32'(stim), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_tt",    32'(tt), 32'h0);
    chk("rst_err",   32'(err_cnt), 32'h0);
    chk("rst_pass",  32'(pass), 32'h0);
    @(negedge CK);
    RN = 1'b1;

    // 1: nominal NOR4 sweep
    run_sweep(1'b0, -1, -1, -1, 7);
    chk("t1_done_cyc", 32'(done_cyc), 32'd49);
    chk("t1_n_done",   32'(n_done), 32'd1);
    chk("t1_stim_c7",  32'(stim_k), 32'd2);
    chk("t1_busy_c7",  32'(busy_k), 32'd1);
    chk("t1_tt",       32'(tt), 32'h0001);
    chk("t1_err",      32'(err_cnt), 32'd0);
    chk("t1_pass",     32'(pass), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_stim_end", 32'(stim), 32'd0);

    // 2: ZN stuck low
    zn_mode = 2'd1;
    run_sweep(1'b0, -1, -1, -1, 7);
    chk("t2_tt",   32'(tt), 32'h0000);
    chk("t2_err",  32'(err_cnt), 32'd1);
    chk("t2_pass", 32'(pass), 32'd0);
`ifdef CELL_TT_FIRST_FAIL_EN
    chk("t2_first_fail", 32'(first_fail), 32'd1);
    chk("t2_fail_idx",   32'(fail_idx), 32'd0);
`endif

    // 3: ZN stuck high
    zn_mode = 2'd2;
    run_sweep(1'b0, -1, -1, -1, 7);
    chk("t3_tt",   32'(tt), 32'hFFFF);
    chk("t3_err",  32'(err_cnt), 32'd15);
    chk("t3_pass", 32'(pass), 32'd0);
`ifdef CELL_TT_FIRST_FAIL_EN
    chk("t3_first_fail", 32'(first_fail), 32'd1);
    chk("t3_fail_idx",   32'(fail_idx), 32'd1);
`endif

    // 4: start pulses while busy are ignored
    zn_mode = 2'd0;
    run_sweep(1'b0, 5, 20, -1, 7);
    chk("t4_done_cyc", 32'(done_cyc), 32'd49);
    chk("t4_n_done",   32'(n_done), 32'd1);
    chk("t4_tt",       32'(tt), 32'h0001);
    chk("t4_err",      32'(err_cnt), 32'd0);
    chk("t4_pass",     32'(pass), 32'd1);
`ifdef CELL_TT_FIRST_FAIL_EN
    chk("t4_first_fail", 32'(first_fail), 32'd0);
`endif

    // 5: reset mid-sweep aborts, then a clean restart
    run_sweep(1'b0, -1, -1, 20, 10);
    chk("t5_busy_c10", 32'(busy_k), 32'd1);
    chk("t5_n_done",   32'(n_done), 32'd0);
    chk("t5_stim",     32'(stim), 32'd0);
    chk("t5_busy",     32'(busy), 32'd0);
    chk("t5_tt",       32'(tt), 32'h0);
    chk("t5_err",      32'(err_cnt), 32'd0);
    @(negedge CK);
    RN = 1'b1;
    run_sweep(1'b0, -1, -1, -1, 7);
    chk("t5r_done_cyc", 32'(done_cyc), 32'd49);
    chk("t5r_tt",       32'(tt), 32'h0001);
    chk("t5r_pass",     32'(pass), 32'd1);

    // 6: zero settle window
    run_sweep(1'b1, -1, -1, -1, 5);
    chk("t6_stim_c5",  32'(stim_k), 32'd5);
    chk("t6_done_cyc", 32'(done_cyc), 32'd17);
    chk("t6_n_done",   32'(n_done), 32'd1);
    chk("t6_tt",       32'(tt0), 32'h0001);
    chk("t6_err",      32'(err_cnt0), 32'd0);
    chk("t6_pass",     32'(pass0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
